// File: rtl/sort_pkg.sv
// Shared defaults, counter widths and FSM encoding for the sort sequencer.
// Consumers import this package and use it to build the serial front/back end of the 5-input sorter.
package sort_pkg;

   localparam int DEF_WIDTH    = 16;
   localparam int DEF_N        = 5;
   localparam int DEF_SORT_LAT = 2;

   localparam int CNT_W  = $clog2(DEF_N);
   localparam int LEN_W  = $clog2(DEF_N + 1);
   localparam int WAIT_W = $clog2(DEF_SORT_LAT + 1);

   typedef enum logic [1:0] {
      COLLECT = 2'd0,
      WAIT    = 2'd1,
      DRAIN   = 2'd2
   } state_t;

endpackage

// File: rtl/sort_sequencer_if.sv
// Signal bundle between the sort sequencer, its serial producer/consumer and the sorter.
// Handshakes: a word moves on a rising clk edge where valid && ready; valid never waits on ready.
interface sort_sequencer_if #(
   parameter int WIDTH = sort_pkg::DEF_WIDTH,
   parameter int N     = sort_pkg::DEF_N
);
   import sort_pkg::*;

   logic [WIDTH-1:0]   in_data;
   logic               in_valid;
   logic               in_last;
   logic               in_ready;
   logic [N*WIDTH-1:0] sort_in;
   logic [N*WIDTH-1:0] sort_out;
   logic [WIDTH-1:0]   out_data;
   logic               out_valid;
   logic               out_last;
   logic               out_ready;
   logic               busy;
   state_t             state;

   modport slave (
      input  in_data, in_valid, in_last, sort_out, out_ready,
      output in_ready, sort_in, out_data, out_valid, out_last, busy, state
   );

   modport master (
      output in_data, in_valid, in_last, sort_out, out_ready,
      input  in_ready, sort_in, out_data, out_valid, out_last, busy, state
   );

endinterface

// File: rtl/sort_frame_buf.sv
// N x WIDTH frame register file: indexed write, whole-frame clear, packed read for the sorter.
module sort_frame_buf
   import sort_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int N     = DEF_N
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 wr_en,
   input  logic [$clog2(N)-1:0] wr_idx,
   input  logic [WIDTH-1:0]     wr_data,
   input  logic                 clr,
   output logic [N*WIDTH-1:0]   rd_flat
);

   logic [WIDTH-1:0] mem [N];

   // Clear wins so every new frame starts from all-zero pads.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N; i++) mem[i] <= '0;
      end else if (clr) begin
         for (int i = 0; i < N; i++) mem[i] <= '0;
      end else if (wr_en) begin
         for (int i = 0; i < N; i++) begin
            if (wr_idx == ($clog2(N))'(i)) mem[i] <= wr_data;
         end
      end
   end

   for (genvar g = 0; g < N; g++) begin : g_pack
      assign rd_flat[g*WIDTH +: WIDTH] = mem[g];
   end

endmodule

// File: rtl/sort_sequencer.sv
// Serial-to-parallel front end and parallel-to-serial back end for the fixed-latency sorter:
// collect a frame, wait out the sorter pipeline, then stream the sorted words largest first.
module sort_sequencer
   import sort_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int N        = DEF_N,
   parameter int SORT_LAT = DEF_SORT_LAT
) (
   input  logic             clk,
   input  logic             rst_n,
   sort_sequencer_if.slave  bus
);

   localparam int CW = $clog2(N);
   localparam int LW = $clog2(N + 1);
   localparam int WW = $clog2(SORT_LAT + 1);

   state_t             state_q, state_d;
   logic [CW-1:0]      in_cnt, out_cnt;
   logic [LW-1:0]      frame_len;
   logic [WW-1:0]      wait_cnt;
   logic [WIDTH-1:0]   result [N];
   logic [N*WIDTH-1:0] frame_flat;
   logic               in_ready_c, out_valid_c, busy_c, last_beat;
   logic               frame_wr, frame_clr, capture;
   logic [WIDTH-1:0]   out_data_c;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= COLLECT;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d     = state_q;
      in_ready_c  = 1'b0;
      out_valid_c = 1'b0;
      busy_c      = 1'b1;
      frame_wr    = 1'b0;
      frame_clr   = 1'b0;
      capture     = 1'b0;
      last_beat   = 1'b0;
      case (state_q)
         COLLECT: begin
            in_ready_c = 1'b1;
            busy_c     = 1'b0;
            frame_wr   = bus.in_valid;
            if (bus.in_valid && (in_cnt == CW'(N - 1) || bus.in_last)) state_d = WAIT;
         end
         WAIT: begin
            if (wait_cnt == WW'(SORT_LAT)) begin
               capture = 1'b1;
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            out_valid_c = 1'b1;
            last_beat   = (LW'(out_cnt) == frame_len - LW'(1));
            if (bus.out_ready && last_beat) begin
               frame_clr = 1'b1;
               state_d   = COLLECT;
            end
         end
         default: state_d = COLLECT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_cnt    <= '0;
         out_cnt   <= '0;
         frame_len <= '0;
         wait_cnt  <= '0;
         for (int i = 0; i < N; i++) result[i] <= '0;
      end else begin
         case (state_q)
            COLLECT: begin
               if (bus.in_valid) begin
                  if (state_d == WAIT) begin
                     frame_len <= LW'(in_cnt) + LW'(1);
                     in_cnt    <= '0;
                  end else begin
                     in_cnt <= in_cnt + CW'(1);
                  end
               end
            end
            WAIT: begin
               if (capture) begin
                  wait_cnt <= '0;
                  for (int i = 0; i < N; i++) result[i] <= bus.sort_out[i*WIDTH +: WIDTH];
               end else begin
                  wait_cnt <= wait_cnt + WW'(1);
               end
            end
            DRAIN: begin
               if (bus.out_ready) begin
                  if (last_beat) out_cnt <= '0;
                  else           out_cnt <= out_cnt + CW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // Outputs are zero outside DRAIN so nothing stale leaks onto the bus.
   always_comb begin
      out_data_c = '0;
      if (state_q == DRAIN) begin
         for (int i = 0; i < N; i++) begin
            if (out_cnt == CW'(i)) out_data_c = result[i];
         end
      end
   end

   sort_frame_buf #(.WIDTH(WIDTH), .N(N)) u_frame_buf (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (frame_wr),
      .wr_idx  (in_cnt),
      .wr_data (bus.in_data),
      .clr     (frame_clr),
      .rd_flat (frame_flat)
   );

   assign bus.sort_in   = frame_flat;
   assign bus.in_ready  = in_ready_c;
   assign bus.out_valid = out_valid_c;
   assign bus.out_last  = last_beat;
   assign bus.out_data  = out_data_c;
   assign bus.busy      = busy_c;
   assign bus.state     = state_q;

endmodule

// File: doc/sort_sequencer.md
Name: sort_sequencer

Overview:
- Streaming front/back-end controller for the 5-input, 16-bit descending sorter (the `sort` module).
- Collects up to N words from a serial valid/ready stream into a frame buffer and drives the frame onto the sorter's parallel inputs.
- Waits out the sorter's fixed pipeline latency, captures the sorted frame, and streams it back out serially, largest first.
- Sits between a serial producer/consumer and the `sort` instance, which is instantiated alongside it at the level above.

Parameters:
- WIDTH, 16: data word width.
- N, 5: frame size; must equal the sorter's input count.
- SORT_LAT, 2: clock edges from the sorter capturing its inputs to its outputs being valid (1 input register + 1 output register).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_data  input  WIDTH  input word.
- in_valid  input  1  in_data valid.
- in_last  input  1  qualifies the final word of a short frame.
- in_ready  output  1  sequencer accepts a word this cycle.
- sort_in  output  N*WIDTH  to sorter in1..in5; word k at bits [k*WIDTH +: WIDTH], k=0 is in1.
- sort_out  input  N*WIDTH  from sorter out1..out5, same packing; out1 is the largest.
- out_data  output  WIDTH  sorted word.
- out_valid  output  1  out_data valid.
- out_last  output  1  final word of the frame.
- out_ready  input  1  consumer accepts a word.
- busy  output  1  high in any state other than COLLECT.

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: state=COLLECT, frame regs=0 (so sort_in=0), in_cnt=0, out_cnt=0, frame_len=0, wait_cnt=0, result regs=0, out_valid=0, out_last=0, out_data=0, busy=0.
- States:
  - COLLECT: in_ready=1.
    - On handshake (in_valid&in_ready): frame[in_cnt] <= in_data; in_cnt++.
    - If in_cnt==N-1 or in_last=1: frame_len <= in_cnt+1, in_cnt <= 0, go to WAIT.
  - WAIT: in_ready=0. wait_cnt increments every cycle.
    - When wait_cnt==SORT_LAT: capture sort_out into result regs, wait_cnt <= 0, go to DRAIN.
    - WAIT therefore lasts SORT_LAT+1 cycles.
    - sort_in is held stable for the whole WAIT.
  - DRAIN: out_valid=1, out_data=result[out_cnt], out_last=(out_cnt==frame_len-1).
    - On out_valid&out_ready: out_cnt++.
    - On the handshake with out_last=1: out_cnt <= 0, clear frame regs to 0, go to COLLECT.
- Short frames: unused frame slots keep the value 0. Because 0 is the minimum value, the pads sort to the tail. Only the first frame_len results are emitted. A real 0 tying with a pad is harmless because the values are equal.
- in_last on the N-th word: behaves the same as a full frame.
- in_last on the first word: frame_len=1.
- out_valid/out_data must stay stable while out_ready=0 (standard valid/ready; no combinational path from out_ready to out_valid).
- in_ready depends only on state; no combinational path from in_valid.
- Latency, full frame with no backpressure: last input handshake at edge E0 → out_valid high from edge E0+SORT_LAT+1 → last output handshake at E0+SORT_LAT+N+1 → in_ready high in the following cycle.
- No overlap: the next frame is not accepted until drain completes. Throughput is 1 frame per (frame_len + SORT_LAT + 1 + frame_len) cycles minimum.
- in_valid while in_ready=0 is ignored; the producer must hold it.
- Reset mid-operation (any state): immediate return to reset values. The partial frame and any undrained results are discarded. out_valid drops asynchronously.
- Arithmetic:
  - in_cnt and out_cnt are $clog2(N) bits; frame_len is $clog2(N+1) bits; wait_cnt is $clog2(SORT_LAT+1) bits.
  - Comparisons are unsigned, and no counter wraps within legal operation.

Decomposition:
- Package sort_pkg holds: WIDTH, N, SORT_LAT defaults; the state enum {COLLECT, WAIT, DRAIN}; the counter-width localparams.
- One sub-module is natural: sort_frame_buf, which holds the N×WIDTH register file with indexed write, clear, and packed read.
- FSM and counters stay in sort_sequencer.

Test Plan:
- Full frame: in 3,9,1,7,5 (no backpressure) → out 9,7,5,3,1; out_last only on 1; first out_valid 3 cycles after the last in handshake.
- Short frame: in 0x0004, 0x0008 with in_last on 0x0008 → out 0x0008, 0x0004 (out_last on the second); exactly 2 output beats.
- Backpressure: full frame 0xFFFF,0,0x8000,0x8000,1, with out_ready toggling 1-0-0-1… → out 0xFFFF,0x8000,0x8000,1,0; data stable while stalled; in_ready=0 until the last output handshake.
- Duplicates/edges: in 0,0,0,0,0 → five 0s; in_last on the first word 0x1234 → single beat 0x1234 with out_last=1.
- Reset mid-DRAIN: assert rst_n=0 after 2 output beats → out_valid=0 and busy=0 immediately; the next frame 2,1,5,4,3 → 5,4,3,2,1 with no residue from the old frame.
- Back-to-back frames: second frame presented with in_valid held high → first word accepted in the cycle after the previous out_last handshake; both frames sorted correctly.
